// File: rtl/bsort_pkg.sv
// Shared constants for the bubble-sort sequencer.
// Early exit on a swap-free pass is enabled with BSORT_EARLY_EXIT_EN.
package bsort_pkg;
  localparam int BSORT_N    = 32;
  localparam int BSORT_W    = 8;
  localparam int BSORT_STEP = 8;
  localparam int SWAP_CNT_W = 16;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_COMPARE = 2'b01;
  localparam logic [1:0] S_SWAP    = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;
endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Control, load and status bundle of the bubble-sort sequencer.
// The master side drives ticks, start and loads; the slave side sorts.
interface bubble_sort_ctrl_if
  import bsort_pkg::*;
#(
  parameter int N = BSORT_N,
  parameter int W = BSORT_W,
  localparam int IDX_W = $clog2(N)
);
  logic                  step_tick;
  logic                  start;
  logic                  load_we;
  logic [IDX_W-1:0]      load_addr;
  logic [W-1:0]          load_data;
  logic [N*W-1:0]        values;
  logic [IDX_W-1:0]      active_idx;
  logic                  swapping;
  logic                  busy;
  logic                  done;
  logic [IDX_W-1:0]      pass_cnt;
  logic [SWAP_CNT_W-1:0] swap_cnt;

  modport master (
    output step_tick, start, load_we,
    output load_addr, load_data,
    input  values, active_idx, swapping,
    input  busy, done, pass_cnt, swap_cnt
  );

  modport slave (
    input  step_tick, start, load_we,
    input  load_addr, load_data,
    output values, active_idx, swapping,
    output busy, done, pass_cnt, swap_cnt
  );
endinterface

// File: rtl/bsort_regfile.sv
// Bar-height storage: flat read bus, pair read at idx/idx+1,
// one write port shared by external loads and in-place swaps.
module bsort_regfile
  import bsort_pkg::*;
#(
  parameter int N = BSORT_N,
  parameter int W = BSORT_W,
  parameter int INIT_STEP = BSORT_STEP,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_we,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [W-1:0]     load_data,
  input  logic             swap_en,
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     rd_a,
  output logic [W-1:0]     rd_b,
  output logic [N*W-1:0]   values
);
  logic [W-1:0]     mem_q [N];
  logic [W-1:0]     mem_d [N];
  logic [IDX_W-1:0] idx_p1;

  function automatic logic [W-1:0] init_val(int k);
    return W'((2**W - 1) - k * INIT_STEP);
  endfunction

  assign idx_p1 = idx + IDX_W'(1);
  assign rd_a   = mem_q[idx];
  assign rd_b   = mem_q[idx_p1];

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign values[g*W +: W] = mem_q[g];
  end

  // a swap rewrites both entries of the pair in one edge
  always_comb begin
    mem_d = mem_q;
    if (swap_en) begin
      mem_d[idx]    = mem_q[idx_p1];
      mem_d[idx_p1] = mem_q[idx];
    end else if (load_we) begin
      mem_d[load_addr] = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) mem_q[k] <= init_val(k);
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/bubble_sort_ctrl.sv
// Tick-paced in-place ascending bubble sort of the bar array.
// Define BSORT_EARLY_EXIT_EN to stop after a pass with no swaps.
module bubble_sort_ctrl
  import bsort_pkg::*;
#(
  parameter int N = BSORT_N,
  parameter int W = BSORT_W,
  parameter int INIT_STEP = BSORT_STEP,
  localparam int IDX_W = $clog2(N)
) (
  input logic               clk,
  input logic               reset,
  bubble_sort_ctrl_if.slave bus
);
  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      i_q, i_d;
  logic [IDX_W-1:0]      pass_end_q, pass_end_d;
  logic [IDX_W-1:0]      pass_cnt_q, pass_cnt_d;
  logic [SWAP_CNT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic                  swapped_q, swapped_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  swapping_q, swapping_d;
  logic                  wr_en, swap_en, adv, last, fin;
  logic [IDX_W-1:0]      i_p1;
  logic [W-1:0]          rd_a, rd_b;

  bsort_regfile #(.N(N), .W(W), .INIT_STEP(INIT_STEP)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .load_we   (wr_en),
    .load_addr (bus.load_addr),
    .load_data (bus.load_data),
    .swap_en   (swap_en),
    .idx       (i_q),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .values    (bus.values)
  );

  assign i_p1 = i_q + IDX_W'(1);
  assign last = (i_p1 >= pass_end_q);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    pass_end_d = pass_end_q;
    pass_cnt_d = pass_cnt_q;
    swap_cnt_d = swap_cnt_q;
    swapped_d  = swapped_q;
    wr_en      = 1'b0;
    swap_en    = 1'b0;
    adv        = 1'b0;
    fin        = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE),
      (state_q == S_DONE): begin
        wr_en = bus.load_we;
        if (bus.start) begin
          state_d    = S_COMPARE;
          i_d        = '0;
          pass_end_d = IDX_W'(N - 1);
          pass_cnt_d = '0;
          swap_cnt_d = '0;
          swapped_d  = 1'b0;
        end else if (bus.load_we) begin
          state_d = S_IDLE;
        end
      end
      (state_q == S_COMPARE): begin
        if (bus.step_tick) begin
          if (rd_a > rd_b) state_d = S_SWAP;
          else adv = 1'b1;
        end
      end
      (state_q == S_SWAP): begin
        if (bus.step_tick) begin
          swap_en   = 1'b1;
          swapped_d = 1'b1;
          if (swap_cnt_q != '1)
            swap_cnt_d = swap_cnt_q + SWAP_CNT_W'(1);
          state_d = S_COMPARE;
          adv     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // swapped_d already includes a swap made on this same tick
`ifdef BSORT_EARLY_EXIT_EN
    fin = (pass_end_q == IDX_W'(1)) || !swapped_d;
`else
    fin = (pass_end_q == IDX_W'(1));
`endif
    if (adv) begin
      if (!last) begin
        i_d = i_p1;
      end else begin
        pass_cnt_d = pass_cnt_q + IDX_W'(1);
        i_d        = '0;
        if (fin) begin
          state_d = S_DONE;
        end else begin
          pass_end_d = pass_end_q - IDX_W'(1);
          swapped_d  = 1'b0;
        end
      end
    end
    busy_d     = (state_d == S_COMPARE) || (state_d == S_SWAP);
    done_d     = (state_d == S_DONE);
    swapping_d = (state_d == S_SWAP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      pass_end_q <= IDX_W'(N - 1);
      pass_cnt_q <= '0;
      swap_cnt_q <= '0;
      swapped_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      swapping_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      pass_end_q <= pass_end_d;
      pass_cnt_q <= pass_cnt_d;
      swap_cnt_q <= swap_cnt_d;
      swapped_q  <= swapped_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      swapping_q <= swapping_d;
    end
  end

  assign bus.active_idx = i_q;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.swap_cnt   = swap_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.swapping   = swapping_q;
endmodule
